// File: rtl/mdu_seq.sv
// mdu_seq: iterative MIPS multiply/divide unit with architectural HI/LO.
// Multiply is radix-2 shift-add and divide is restoring shift-subtract.
// Both run for WIDTH cycles in CALC, then apply sign correction in FIN.
// Define MDU_DIV_EN to build the divider. Without it, div/divu launch
// nothing: they pulse done on the next edge and leave HI/LO unchanged.
module mdu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              launch;
    logic [CW-1:0]     count;
    logic [DW-1:0]     acc;
    logic [WIDTH-1:0]  opnd;
    logic              neg_lo;

    logic              signed_op;
    logic              a_neg;
    logic              b_neg;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic [WIDTH:0]    mul_sum;
    logic [DW-1:0]     mul_step;
    logic [DW-1:0]     prod;
    logic [WIDTH-1:0]  res_hi;
    logic [WIDTH-1:0]  res_lo;
`ifdef MDU_DIV_EN
    logic              is_div;
    logic              neg_hi;
    logic [WIDTH-1:0]  a_raw;
    logic [WIDTH:0]    rem_sh;
    logic [WIDTH:0]    div_diff;
    logic [DW-1:0]     div_step;
`endif

    // Next-state logic; launch marks an accepted start
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        case (state)
            IDLE: begin
`ifdef MDU_DIV_EN
                if (start) begin
                    state_next = CALC;
                    launch     = 1'b1;
                end
`else
                if (start && !op[1]) begin
                    state_next = CALC;
                    launch     = 1'b1;
                end
`endif
            end
            CALC:    if (count == '0) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Operand magnitudes, one iteration step and the sign-corrected result
    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        a_mag     = a_neg ? (~a + WIDTH'(1)) : a;
        b_mag     = b_neg ? (~b + WIDTH'(1)) : b;
        mul_sum   = {1'b0, acc[DW-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_step  = {mul_sum, acc[WIDTH-1:1]};
        prod      = neg_lo ? (~acc + DW'(1)) : acc;
        res_hi    = prod[DW-1:WIDTH];
        res_lo    = prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
        rem_sh    = acc[DW-1:WIDTH-1];
        div_diff  = rem_sh - {1'b0, opnd};
        div_step  = div_diff[WIDTH] ? {acc[DW-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        if (is_div) begin
            if (opnd == '0) begin
                res_lo = '1;
                res_hi = a_raw;
            end else begin
                res_lo = neg_lo ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
                res_hi = neg_hi ? (~acc[DW-1:WIDTH] + WIDTH'(1)) : acc[DW-1:WIDTH];
            end
        end
`endif
    end

    // Datapath, HI/LO and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            acc    <= '0;
            opnd   <= '0;
            neg_lo <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef MDU_DIV_EN
            is_div <= 1'b0;
            neg_hi <= 1'b0;
            a_raw  <= '0;
`endif
        end else begin
            busy <= (state_next != IDLE);
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (launch) begin
                        count  <= CW'(WIDTH - 1);
                        neg_lo <= a_neg ^ b_neg;
`ifdef MDU_DIV_EN
                        is_div <= op[1];
                        neg_hi <= op[1] ? a_neg : (a_neg ^ b_neg);
                        a_raw  <= a;
                        if (op[1]) begin
                            acc  <= {{WIDTH{1'b0}}, a_mag};
                            opnd <= b_mag;
                        end else begin
                            acc  <= {{WIDTH{1'b0}}, b_mag};
                            opnd <= a_mag;
                        end
`else
                        acc  <= {{WIDTH{1'b0}}, b_mag};
                        opnd <= a_mag;
`endif
                    end
`ifndef MDU_DIV_EN
                    if (start && op[1]) done <= 1'b1;
`endif
                end
                CALC: begin
                    count <= count - CW'(1);
`ifdef MDU_DIV_EN
                    acc   <= is_div ? div_step : mul_step;
`else
                    acc   <= mul_step;
`endif
                end
                FIN: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
